// File: rtl/adxl362_spi_slave.sv
// adxl362_spi_slave
// SPI mode-0 responder that emulates the ADXL362 register interface.
// SCLK/CS/MOSI are oversampled on iclk through 2-flop synchronizers and
// decoded into READ (0x0B) / WRITE (0x0A) commands with auto-incrementing
// 8-bit addresses. X/Y reads come from a snapshot taken at CS fall.
//
// Ports:
//   iclk          system clock
//   rst           asynchronous active-high reset
//   sclk/cs/mosi  SPI pins from the master (asynchronous to iclk)
//   miso          SPI slave-out data (registered)
//   x_sample      {X_H, X_L}, latched into the shadow on sample_valid
//   y_sample      {Y_H, Y_L}, latched into the shadow on sample_valid
//   sample_valid  one-cycle load strobe for the shadow registers
//   power_ctl     POWER_CTL register (0x2D)
//   soft_reset    one-cycle pulse when 0x52 is written to 0x1F
//   busy          synchronized CS asserted
//   frame_done    one-cycle pulse at CS rise after >= 1 complete data byte
module adxl362_spi_slave #(
    parameter logic [7:0] DEVID_AD  = 8'hAD,
    parameter logic [7:0] DEVID_MST = 8'h1D,
    parameter logic [7:0] PARTID    = 8'hF2
) (
    input  logic        iclk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        cs,
    input  logic        mosi,
    output logic        miso,
    input  logic [15:0] x_sample,
    input  logic [15:0] y_sample,
    input  logic        sample_valid,
    output logic [7:0]  power_ctl,
    output logic        soft_reset,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_RDATA  = 3'd3,
        ST_WDATA  = 3'd4,
        ST_IGNORE = 3'd5
    } state_t;

    localparam logic [7:0] CMD_WRITE   = 8'h0A;
    localparam logic [7:0] CMD_READ    = 8'h0B;
    localparam logic [7:0] ADDR_SRST   = 8'h1F;
    localparam logic [7:0] ADDR_PWRCTL = 8'h2D;
    localparam logic [7:0] SRST_KEY    = 8'h52;

    logic [1:0]  sclk_sync_r;
    logic [1:0]  cs_sync_r;
    logic [1:0]  mosi_sync_r;
    logic        sclk_prev_r;
    logic        cs_prev_r;
    logic        cs_seen_r;

    state_t      state_r;
    logic [2:0]  bit_cnt_r;
    logic [7:0]  shift_r;
    logic [7:0]  tx_r;
    logic [7:0]  addr_r;
    logic        is_read_r;
    logic        data_byte_r;
    logic [15:0] shadow_x_r;
    logic [15:0] shadow_y_r;
    logic [15:0] snap_x_r;
    logic [15:0] snap_y_r;
    logic        miso_r;
    logic [7:0]  power_ctl_r;
    logic        soft_reset_r;
    logic        busy_r;
    logic        frame_done_r;

    logic        sclk_s;
    logic        cs_s;
    logic        mosi_s;
    logic        sclk_rise_s;
    logic        sclk_fall_s;
    logic        cs_rise_s;
    logic        cs_fall_s;
    logic [7:0]  rx_byte_s;
    logic [7:0]  rd_byte_s;

    // Register map as seen by a read at address a.
    function automatic logic [7:0] reg_read(input logic [7:0]  a,
                                            input logic [15:0] sx,
                                            input logic [15:0] sy,
                                            input logic [7:0]  pc);
        case (a)
            8'h00:       reg_read = DEVID_AD;
            8'h01:       reg_read = DEVID_MST;
            8'h02:       reg_read = PARTID;
            8'h0E:       reg_read = sx[7:0];
            8'h0F:       reg_read = sx[15:8];
            8'h10:       reg_read = sy[7:0];
            8'h11:       reg_read = sy[15:8];
            ADDR_PWRCTL: reg_read = pc;
            default:     reg_read = 8'h00;
        endcase
    endfunction

    assign sclk_s      = sclk_sync_r[1];
    assign cs_s        = cs_sync_r[1];
    assign mosi_s      = mosi_sync_r[1];
    assign sclk_rise_s = ~sclk_prev_r & sclk_s;
    assign sclk_fall_s = sclk_prev_r & ~sclk_s;
    assign cs_rise_s   = ~cs_prev_r & cs_s;
    assign cs_fall_s   = cs_prev_r & ~cs_s;
    assign rx_byte_s   = {shift_r[6:0], mosi_s};
    assign rd_byte_s   = reg_read(addr_r, snap_x_r, snap_y_r, power_ctl_r);

    assign miso       = miso_r;
    assign power_ctl  = power_ctl_r;
    assign soft_reset = soft_reset_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

    // Pin synchronizers and previous-value flops for edge detection.
    // CS resets to "low" so a frame cut by reset only restarts after CS has
    // been seen high again; only a genuine high->low counts as a new frame.
    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            sclk_sync_r <= 2'b00;
            cs_sync_r   <= 2'b00;
            mosi_sync_r <= 2'b00;
            sclk_prev_r <= 1'b0;
            cs_prev_r   <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[0], sclk};
            cs_sync_r   <= {cs_sync_r[0], cs};
            mosi_sync_r <= {mosi_sync_r[0], mosi};
            sclk_prev_r <= sclk_s;
            cs_prev_r   <= cs_s;
        end
    end

    // Protocol FSM, register file, sample shadow/snapshot and status outputs.
    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'h00;
            tx_r         <= 8'h00;
            addr_r       <= 8'h00;
            is_read_r    <= 1'b0;
            data_byte_r  <= 1'b0;
            shadow_x_r   <= 16'h0000;
            shadow_y_r   <= 16'h0000;
            snap_x_r     <= 16'h0000;
            snap_y_r     <= 16'h0000;
            miso_r       <= 1'b0;
            power_ctl_r  <= 8'h00;
            soft_reset_r <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            cs_seen_r    <= 1'b0;
        end else begin
            soft_reset_r <= 1'b0;
            frame_done_r <= 1'b0;
            // busy stays low after reset until CS has genuinely been high
            busy_r       <= ~cs_s & cs_seen_r;
            if (cs_s) begin
                cs_seen_r <= 1'b1;
            end
            if (sample_valid) begin
                shadow_x_r <= x_sample;
                shadow_y_r <= y_sample;
            end

            if (cs_rise_s) begin
                state_r      <= ST_IDLE;
                miso_r       <= 1'b0;
                frame_done_r <= data_byte_r;
                data_byte_r  <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (cs_fall_s) begin
                            state_r     <= ST_CMD;
                            bit_cnt_r   <= 3'd0;
                            data_byte_r <= 1'b0;
                            miso_r      <= 1'b0;
                            // nonblocking: a same-cycle sample_valid only reaches the shadow
                            snap_x_r    <= shadow_x_r;
                            snap_y_r    <= shadow_y_r;
                        end
                    end
                    ST_CMD: begin
                        if (sclk_rise_s) begin
                            shift_r   <= rx_byte_s;
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                if (rx_byte_s == CMD_READ) begin
                                    is_read_r <= 1'b1;
                                    state_r   <= ST_ADDR;
                                end else if (rx_byte_s == CMD_WRITE) begin
                                    is_read_r <= 1'b0;
                                    state_r   <= ST_ADDR;
                                end else begin
                                    state_r   <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (sclk_rise_s) begin
                            shift_r   <= rx_byte_s;
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                addr_r  <= rx_byte_s;
                                state_r <= is_read_r ? ST_RDATA : ST_WDATA;
                            end
                        end
                    end
                    ST_RDATA: begin
                        // bit_cnt_r counts rises, so it is 0 on the fall that starts a byte
                        if (sclk_fall_s) begin
                            if (bit_cnt_r == 3'd0) begin
                                tx_r   <= rd_byte_s;
                                miso_r <= rd_byte_s[7];
                                addr_r <= addr_r + 8'd1;
                            end else begin
                                tx_r   <= {tx_r[6:0], 1'b0};
                                miso_r <= tx_r[6];
                            end
                        end else if (sclk_rise_s) begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                data_byte_r <= 1'b1;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (sclk_rise_s) begin
                            shift_r   <= rx_byte_s;
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                data_byte_r <= 1'b1;
                                addr_r      <= addr_r + 8'd1;
                                if (addr_r == ADDR_PWRCTL) begin
                                    power_ctl_r <= rx_byte_s;
                                end else if ((addr_r == ADDR_SRST) && (rx_byte_s == SRST_KEY)) begin
                                    power_ctl_r  <= 8'h00;
                                    soft_reset_r <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_IGNORE: begin
                        miso_r <= 1'b0;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        miso_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
